// File: rtl/chunked_comparator_if.sv
// Operand/result handshake bundle for chunked_comparator.
// The master drives operands and accepts results; the comparator is the slave.
interface chunked_comparator_if #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CU_W   = $clog2(NCHUNK) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       mode;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             eq;
  logic             lt;
  logic             gt;
  logic             match;
  logic [CU_W-1:0]  chunks_used;

  modport master (
    output in_valid, a, b, mode, is_signed, out_ready,
    input  in_ready, out_valid, eq, lt, gt, match, chunks_used
  );

  modport slave (
    input  in_valid, a, b, mode, is_signed, out_ready,
    output in_ready, out_valid, eq, lt, gt, match, chunks_used
  );
endinterface

// File: rtl/chunked_comparator.sv
// Multi-cycle magnitude/equality comparator: walks CHUNK bits per cycle from
// the MSB end and stops at the first differing chunk.
module chunked_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic              clk,
  input logic              rst_n,
  chunked_comparator_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CU_W   = $clog2(NCHUNK) + 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       mode_q, mode_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;
  logic             match_q, match_d;
  logic [CU_W-1:0]  cu_q, cu_d;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic             last_chunk;

  function automatic logic sel_match(input logic [2:0] m, input logic e,
                                     input logic l, input logic g);
    case (m)
      3'd0:    sel_match = e;
      3'd1:    sel_match = ~e;
      3'd2:    sel_match = l;
      3'd3:    sel_match = l | e;
      3'd4:    sel_match = g;
      3'd5:    sel_match = g | e;
      default: sel_match = 1'b0;
    endcase
  endfunction

  // Operands are shifted left as chunks are consumed, so the live chunk is
  // always the top CHUNK bits.
  assign chunk_a    = a_q[WIDTH-1 -: CHUNK];
  assign chunk_b    = b_q[WIDTH-1 -: CHUNK];
  assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    match_d = match_q;
    cu_d    = cu_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          // Flipping both sign bits maps two's-complement order onto unsigned
          // order, so the chunk walk itself is always unsigned.
          a_d     = bus.is_signed ? (bus.a ^ MSB_MASK) : bus.a;
          b_d     = bus.is_signed ? (bus.b ^ MSB_MASK) : bus.b;
          mode_d  = bus.mode;
          idx_d   = '0;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if ((chunk_a != chunk_b) || last_chunk) begin
          eq_d    = (chunk_a == chunk_b);
          lt_d    = (chunk_a <  chunk_b);
          gt_d    = (chunk_a >  chunk_b);
          match_d = sel_match(mode_q, chunk_a == chunk_b,
                              chunk_a < chunk_b, chunk_a > chunk_b);
          cu_d    = CU_W'(idx_q) + CU_W'(1);
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          a_d   = a_q << CHUNK;
          b_d   = b_q << CHUNK;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
      gt_q        <= 1'b0;
      match_q     <= 1'b0;
      cu_q        <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      eq_q        <= eq_d;
      lt_q        <= lt_d;
      gt_q        <= gt_d;
      match_q     <= match_d;
      cu_q        <= cu_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.eq          = eq_q;
  assign bus.lt          = lt_q;
  assign bus.gt          = gt_q;
  assign bus.match       = match_q;
  assign bus.chunks_used = cu_q;
endmodule
